// File: rtl/qnna_mac_ctrl.sv
// QNNA MAC array job sequencer: buffers matmul descriptors, launches one job at a
// time under a watchdog, and returns in-order completion records with an interrupt.
module qnna_mac_ctrl #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] TIMEOUT = 32'd16777216,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_m,
  input  logic [15:0]      cmd_n,
  input  logic [15:0]      cmd_k,
  input  logic             cmd_relu,
  input  logic [3:0]       cmd_tag,
  output logic             mac_start,
  input  logic             mac_done,
  output logic             mac_rst,
  output logic [15:0]      mac_dim_m,
  output logic [15:0]      mac_dim_n,
  output logic [15:0]      mac_dim_k,
  output logic             mac_relu_en,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_tag,
  output logic [1:0]       rsp_err,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             busy,
  output logic             irq
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ZERO = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] n;
    logic [15:0] k;
    logic        relu;
    logic [3:0]  tag;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP, S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  job_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  job_t              job_q, job_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              mac_start_q, mac_start_d;
  logic              mac_rst_q, mac_rst_d;
  logic [15:0]       dim_m_q, dim_m_d;
  logic [15:0]       dim_n_q, dim_n_d;
  logic [15:0]       dim_k_q, dim_k_d;
  logic              relu_q, relu_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_tag_q, rsp_tag_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  rsp_cycles_q, rsp_cycles_d;
  logic              busy_q, busy_d;
  logic              irq_q, irq_d;

  logic              push;
  logic              pop;
  logic              fifo_nonempty;
  logic              dim_zero;
  logic [CNT_W-1:0]  cnt_inc;
  job_t              cmd_job;

  assign push          = cmd_valid && cmd_ready_q;
  assign fifo_nonempty = (count_q != '0);
  assign dim_zero      = (job_q.m == '0) || (job_q.n == '0) || (job_q.k == '0);
  assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    cmd_job.m    = cmd_m;
    cmd_job.n    = cmd_n;
    cmd_job.k    = cmd_k;
    cmd_job.relu = cmd_relu;
    cmd_job.tag  = cmd_tag;
  end

  // Descriptor storage; emptiness is tracked by count_q, so contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_job;
    end
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    mac_start_d  = 1'b0;
    mac_rst_d    = 1'b0;
    dim_m_d      = dim_m_q;
    dim_n_d      = dim_n_q;
    dim_k_d      = dim_k_q;
    relu_d       = relu_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    pop          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (dim_zero) begin
          rsp_tag_d    = job_q.tag;
          rsp_err_d    = ERR_ZERO;
          rsp_cycles_d = '0;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          dim_m_d     = job_q.m;
          dim_n_d     = job_q.n;
          dim_k_d     = job_q.k;
          relu_d      = job_q.relu;
          mac_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = cnt_inc;
        first_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // cnt_q holds cycles elapsed since the start pulse; done from the
        // previous job may still be high on the first WAIT cycle.
        cnt_d   = cnt_inc;
        first_d = 1'b0;
        if (mac_done && !first_q) begin
          rsp_tag_d    = job_q.tag;
          rsp_err_d    = ERR_OK;
          rsp_cycles_d = cnt_q;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rsp_tag_d    = job_q.tag;
          rsp_err_d    = ERR_TMO;
          rsp_cycles_d = cnt_q;
          mac_rst_d    = 1'b1;
          state_d      = S_FLUSH;
        end
      end
      S_FLUSH: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            state_d = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer/occupancy bookkeeping and status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      job_d_unused_guard();
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - FCNT_W'(1);
    end
    cmd_ready_d = (count_d != FCNT_W'(DEPTH));
    busy_d      = (count_d != '0) || (state_d != S_IDLE);
    irq_d       = rsp_valid_d;
  end

  function automatic void job_d_unused_guard();
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      job_q        <= '0;
      cnt_q        <= '0;
      first_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      mac_start_q  <= 1'b0;
      mac_rst_q    <= 1'b1;
      dim_m_q      <= '0;
      dim_n_q      <= '0;
      dim_k_q      <= '0;
      relu_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= '0;
      rsp_cycles_q <= '0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      job_q        <= pop ? mem_q[rd_ptr_q] : job_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      cmd_ready_q  <= cmd_ready_d;
      mac_start_q  <= mac_start_d;
      mac_rst_q    <= mac_rst_d;
      dim_m_q      <= dim_m_d;
      dim_n_q      <= dim_n_d;
      dim_k_q      <= dim_k_d;
      relu_q       <= relu_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign mac_start   = mac_start_q;
  assign mac_rst     = mac_rst_q;
  assign mac_dim_m   = dim_m_q;
  assign mac_dim_n   = dim_n_q;
  assign mac_dim_k   = dim_k_q;
  assign mac_relu_en = relu_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign busy        = busy_q;
  assign irq         = irq_q;

endmodule
